// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package addsub_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the arithmetic slice processed per cycle
   localparam int NIBBLE_W = 4;

   // Operation select encoding for in_sub
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Command and result handshake bundle for addsub_seq_ctrl.
// slave  : the sequencer (accepts commands, produces results)
// master : the requester/consumer side
interface addsub_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             out_ovf;
   logic             out_zero;

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
   );

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
   );
endinterface

// File: rtl/addsub_seq_ctrl_nibble.sv
// Combinational 4-bit add/sub slice built as a ripple of full adders.
// cin is kept separate from inv_b so the slice can be chained through a
// registered carry; the caller supplies inv_b as cin only on the first nibble.
module addsub_nibble
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                inv_b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0]   c;
   logic [NIBBLE_W-1:0] bx;

   // Full-adder ripple across the nibble
   always_comb begin
      c    = '0;
      bx   = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         bx[i]   = b[i] ^ inv_b;
         sum[i]  = a[i] ^ bx[i] ^ c[i];
         c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
      cout = c[NIBBLE_W];
   end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor. Operands are captured on accept,
// then one 4-bit slice is evaluated per cycle, LSB nibble first, with the
// carry held in a register between steps. Flags are produced on the last step.
module addsub_seq_ctrl
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   addsub_seq_ctrl_if.slave   bus,
   output logic               busy
);

   localparam int NIB_CNT = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

   if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_chk
      $error("addsub_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
   end

   state_t                state;
   logic [WIDTH-1:0]      a_q;
   logic [WIDTH-1:0]      b_q;
   logic                  sub_q;
   logic                  carry_q;
   logic [IDX_W-1:0]      idx;

   logic [NIBBLE_W-1:0]   a_nib;
   logic [NIBBLE_W-1:0]   b_nib;
   logic [NIBBLE_W-1:0]   sum_nib;
   logic                  cout_nib;
   logic [WIDTH-1:0]      res_next;
   logic                  accept;
   logic                  last_step;

   // Signed overflow: operands agree in sign but the result does not
   function automatic logic ovf_flag(input logic a_msb, input logic beff_msb,
                                     input logic s_msb);
      return (a_msb == beff_msb) && (s_msb != a_msb);
   endfunction

   assign accept    = (state == IDLE) && bus.in_valid && bus.in_ready;
   assign last_step = (idx == IDX_W'(NIB_CNT - 1));

   // Select the active nibble and form the result with it merged in
   always_comb begin
      a_nib    = a_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
      b_nib    = b_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
      res_next = bus.out_sum;
      res_next[NIBBLE_W*int'(idx) +: NIBBLE_W] = sum_nib;
   end

   addsub_nibble u_nibble (
      .a     (a_nib),
      .b     (b_nib),
      .inv_b (sub_q),
      .cin   (carry_q),
      .sum   (sum_nib),
      .cout  (cout_nib)
   );

   // Operand capture on accept; the requester may drop operands afterwards
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= bus.in_a;
         b_q   <= bus.in_b;
         sub_q <= bus.in_sub;
      end
   end

   // Sequencer FSM with registered handshake, result and flag outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_carry <= 1'b0;
         bus.out_ovf   <= 1'b0;
         bus.out_zero  <= 1'b0;
         idx           <= '0;
         carry_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  carry_q      <= (bus.in_sub == OP_SUB);
                  idx          <= '0;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               bus.out_sum <= res_next;
               carry_q     <= cout_nib;
               if (last_step) begin
                  idx           <= '0;
                  bus.out_valid <= 1'b1;
                  bus.out_carry <= cout_nib;
                  bus.out_ovf   <= ovf_flag(a_q[WIDTH-1], b_q[WIDTH-1] ^ sub_q,
                                            sum_nib[NIBBLE_W-1]);
                  bus.out_zero  <= (res_next == '0);
                  state         <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed and randomized self-checking bench for addsub_seq_ctrl (WIDTH=16).
module tb_addsub_seq_ctrl;

   logic clk;
   logic rst;
   logic busy;
   int   errors;
   int   checks;

   addsub_seq_ctrl_if #(.WIDTH(16)) bus ();

   addsub_seq_ctrl #(.WIDTH(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a command and return at the negedge just after it is accepted
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("issue_timeout", 32'(n), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = 16'hDEAD;
      bus.in_b     = 16'hBEEF;
   endtask

   // Called at the negedge right after accept: checks latency and the result,
   // optionally holds backpressure, then consumes the result
   task automatic wait_result(input string tag, input logic [15:0] es, input logic ec,
                              input logic ev, input logic ez, input int hold);
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd4);
      chk({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
      chk({tag, "_carry"}, 32'(bus.out_carry), 32'(ec));
      chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ev));
      chk({tag, "_zero"}, 32'(bus.out_zero), 32'(ez));
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_drop"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
   endtask

   initial begin
      logic [15:0] ra, rb, beff, rs;
      logic        rsub, rc, rv;
      logic [16:0] full;
      int          seen;

      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", {28'd0, bus.out_carry, bus.out_ovf, bus.out_zero, 1'b0}, 32'd0);
      chk("rst_sum", 32'(bus.out_sum), 32'd0);
      rst = 1'b0;

      issue(16'h1234, 16'h0FFF, 1'b0);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_in_ready", 32'(bus.in_ready), 32'd0);
      wait_result("add", 16'h2233, 1'b0, 1'b0, 1'b0, 0);
      chk("idle_busy", 32'(busy), 32'd0);

      issue(16'hFFFF, 16'h0001, 1'b0);
      wait_result("wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 0);
      issue(16'h7FFF, 16'h0001, 1'b0);
      wait_result("addovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1);
      issue(16'h0005, 16'h0007, 1'b1);
      wait_result("borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
      issue(16'h8000, 16'h0001, 1'b1);
      wait_result("subovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, 2);

      // Backpressure with a competing command presented during DONE
      issue(16'h0003, 16'h0004, 1'b0);
      repeat (4) @(negedge clk);
      chk("bp_valid0", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h1111;
      bus.in_b     = 16'h2222;
      bus.in_sub   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {bus.out_valid, bus.in_ready, busy, bus.out_carry,
                         bus.out_ovf, bus.out_zero, 10'd0, bus.out_sum},
             {1'b1, 1'b0, 1'b1, 3'b000, 10'd0, 16'h0007});
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp_release", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_accept", 32'(bus.in_ready), 32'd0);
      wait_result("pending", 16'h3333, 1'b0, 1'b0, 1'b0, 0);

      // Reset during the second RUN cycle discards the operation
      issue(16'h1234, 16'h1111, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ctrl", {29'd0, bus.in_ready, bus.out_valid, busy}, 32'b100);
      chk("abort_outs", {13'd0, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_sum}, 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("abort_novalid", 32'(seen), 32'd0);

      // Random commands against an arithmetic reference
      for (int n = 0; n < 1000; n++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rsub = 1'($urandom);
         if (n % 50 == 0) rb = ra;
         beff = rsub ? ~rb : rb;
         full = {1'b0, ra} + {1'b0, beff} + {16'd0, rsub};
         rs   = full[15:0];
         rc   = full[16];
         rv   = (ra[15] == beff[15]) && (rs[15] != ra[15]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(ra, rb, rsub);
         wait_result("rnd", rs, rc, rv, (rs == 16'd0), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Multi-cycle sequencer that performs WIDTH-bit add/subtract by running a 4-bit add/sub slice one nibble per cycle, LSB nibble first, with a registered carry between cycles.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port) and owns all sequencing: operand capture, nibble select, carry chaining, and flag generation.
- Trades latency for area on paths too wide for a single combinational ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. Elaboration error otherwise.
- NIB_CNT, WIDTH/4, derived local constant: number of nibble steps. Not user-overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B (two's complement).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  WIDTH  result.
- out_carry  out  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, RUN, DONE. State register encoding is local to this block.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_carry=0, out_ovf=0, out_zero=0, nibble index=0, carry reg=0. Reset overrides every other event, including mid-RUN; an in-flight operation is discarded and produces no result.
- IDLE: in_ready=1. On accept, latch in_a, in_b, and in_sub; set carry reg=in_sub and index=0; go to RUN.
- RUN: in_ready=0. Each cycle, nibble[index] of A is added to nibble[index] of (B XOR {4{sub}}) plus the carry reg. The 4-bit sum is written to result[4*index+3:4*index]. The carry reg takes the slice carry-out. Index increments.
- RUN exit: after the step with index = NIB_CNT-1, go to DONE.
- Flags at the final step:
  - out_carry = final slice carry.
  - out_ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]), where Beff is the inverted B for subtract.
  - out_zero = (full result == 0).
- Latency: an accept on edge N gives out_valid=1 after edge N+NIB_CNT (4 cycles for WIDTH=16).
- Result visibility: out_sum may show partial nibbles during RUN; consumers sample only when out_valid=1.
- DONE: out_valid=1. out_sum and the flags are held stable while out_ready=0; backpressure is unlimited.
- DONE exit: on out_ready=1, go to IDLE and drop out_valid in the next cycle. in_ready returns that same next cycle.
- Throughput: no command/result overlap; at most one operation is in flight, so throughput is 1 per NIB_CNT+2 cycles at best.
- in_valid while not in_ready: ignored. Operands need not be held by the requester after accept.
- Arithmetic: all operations are modulo 2^WIDTH. No sign extension; the block itself is signedness-agnostic apart from the ovf flag.

Decomposition:
- Shared package addsub_pkg holds:
  - state enum type (IDLE/RUN/DONE);
  - NIBBLE_W = 4;
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module, addsub_nibble: combinational 4-bit slice with ports a[3:0], b[3:0], inv_b, cin, sum[3:0], cout.
  - cin is an independent input, not tied to inv_b; this is required for chaining.
  - The slice is built from full adders.

Test Plan:
- Add, no carry: A=0x1234, B=0x0FFF, sub=0. Expect out_sum=0x2233, carry=0, ovf=0, zero=0, with out_valid exactly 4 cycles after accept.
- Add, wrap: A=0xFFFF, B=0x0001, sub=0. Expect out_sum=0x0000, carry=1, ovf=0, zero=1. Separately, A=0x7FFF, B=0x0001 gives 0x8000, carry=0, ovf=1.
- Subtract with borrow, then signed overflow:
  - A=0x0005, B=0x0007, sub=1 gives 0xFFFE, carry=0, ovf=0.
  - A=0x8000, B=0x0001, sub=1 gives 0x7FFF, carry=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Outputs stay stable, in_ready=0, and a concurrent in_valid with A=0x1111 is not accepted. Release out_ready; next cycle in_ready=1, then the pending command is accepted.
- Reset mid-RUN: assert rst for 1 cycle at the 2nd RUN cycle. Next cycle state=IDLE, all outputs at reset values, and no out_valid pulse ever appears for the aborted command.
- Back-to-back plus random: 1000 random A/B/sub commands with random in_valid/out_ready gaps, compared against a reference model of (A ± B) mod 2^16 with the flags. Also check that the accept-to-valid gap is always 4 cycles.
